// File: rtl/mac_pkg.sv
// mac_pkg: state encoding and default widths shared by the mac datapath blocks
package mac_pkg;
    localparam int MAC_DATA_W = 4;
    localparam int MAC_LEN_W  = 4;
    typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DRAIN} mac_seq_state_t;
endpackage

// File: rtl/mac_operand_fifo.sv
// mac_operand_fifo: DEPTH-entry synchronous FIFO, head entry visible combinationally on dout
module mac_operand_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic                   sys_clock,
    input  logic                   sys_rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]   cnt_q, cnt_d;
    always_comb begin
        wr_d  = push ? wr_q + PW'(1) : wr_q;
        rd_d  = pop ? rd_q + PW'(1) : rd_q;
        cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
    always_ff @(posedge sys_clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge sys_clock) begin
        if (push) mem_q[wr_q] <= din;
    end
    assign dout  = mem_q[rd_q];
    assign count = cnt_q;
    assign full  = cnt_q == (PW+1)'(DEPTH);
    assign empty = cnt_q == '0;
endmodule

// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer: frames buffered operand pairs into sclr/load sequences for the mac stage
module mac_operand_sequencer
    import mac_pkg::*;
#(
    parameter int DATA_W  = MAC_DATA_W,
    parameter int DEPTH   = 4,
    parameter int LEN_W   = MAC_LEN_W,
    parameter int MAC_LAT = 1
) (
    input  logic              sys_clock,
    input  logic              sys_rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_last,
    output logic              mac_sclr,
    output logic              mac_load,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    output logic              vec_done,
    output logic [LEN_W-1:0]  vec_len,
    output logic              len_ovf,
    output logic              busy
);
    localparam int EW = 2 * DATA_W + 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int WW = $clog2(MAC_LAT + 1) + 1;
    mac_seq_state_t    state_q, state_d;
    logic [EW-1:0]     head;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full, fifo_empty, push, pop;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic              ovf_q, ovf_d, sclr_q, sclr_d, load_q, load_d;
    logic              done_q, done_d, busy_q, busy_d;
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    mac_operand_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .sys_clock (sys_clock),
        .sys_rst_n (sys_rst_n),
        .push      (push),
        .pop       (pop),
        .din       ({in_a, in_b, in_last}),
        .dout      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        wait_d  = '0;
        done_d  = 1'b0;
        len_d   = len_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: state_d = fifo_count != '0 ? CLEAR : IDLE;
            CLEAR, STREAM: begin
                pop     = !fifo_empty;
                state_d = pop && head[0] ? DRAIN : STREAM;
            end
            DRAIN: begin
                done_d  = wait_q == WW'(MAC_LAT);
                wait_d  = wait_q + WW'(1);
                state_d = done_d ? IDLE : DRAIN;
            end
            default: state_d = IDLE;
        endcase
        // The CLEAR cycle's own pop counts as the first element.
        if (state_q == CLEAR) begin
            len_d = LEN_W'(1);
            ovf_d = 1'b0;
        end else if (pop) begin
            len_d = &len_q ? len_q : len_q + LEN_W'(1);
            ovf_d = ovf_q || &len_q;
        end
        sclr_d = state_d == CLEAR;
        load_d = pop;
        a_d    = pop ? head[EW-1 -: DATA_W] : a_q;
        b_d    = pop ? head[1 +: DATA_W] : b_q;
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge sys_clock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            wait_q  <= '0;
            sclr_q  <= 1'b0;
            load_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
            wait_q  <= wait_d;
            sclr_q  <= sclr_d;
            load_q  <= load_d;
            a_q     <= a_d;
            b_q     <= b_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end
    assign mac_sclr = sclr_q;
    assign mac_load = load_q;
    assign mac_a    = a_q;
    assign mac_b    = b_q;
    assign vec_done = done_q;
    assign vec_len  = len_q;
    assign len_ovf  = ovf_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_mac_operand_sequencer.sv
// tb_mac_operand_sequencer: directed vector table plus hand-timed corner sequences
module tb_mac_operand_sequencer;
    localparam int LAT = 6;
    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       last;
        logic [3:0] len;
        logic       ovf;
    } vec_rec_t;
    logic       sys_clock = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_a = '0;
    logic [3:0] in_b = '0;
    logic       in_last = 1'b0;
    logic       in_ready, mac_sclr, mac_load, vec_done, len_ovf, busy;
    logic [3:0] mac_a, mac_b, vec_len;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int pend = 0;
    int last_ld = 0;
    logic [7:0] ld_q[$];
    logic [4:0] dn_q[$];
    int ld_cyc[$];
    int sc_cyc[$];
    vec_rec_t tbl[23];

    mac_operand_sequencer #(.DATA_W(4), .DEPTH(4), .LEN_W(4), .MAC_LAT(LAT)) dut (
        .sys_clock (sys_clock),
        .sys_rst_n (sys_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .mac_sclr  (mac_sclr),
        .mac_load  (mac_load),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .vec_done  (vec_done),
        .vec_len   (vec_len),
        .len_ovf   (len_ovf),
        .busy      (busy)
    );

    always #5 sys_clock = ~sys_clock;
    always @(posedge sys_clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Event log sampled on the falling edge, away from the active edge.
    always @(negedge sys_clock) begin
        if (!sys_rst_n) pend = 0;
        else begin
            if (mac_sclr) begin
                sc_cyc.push_back(cyc);
                pend++;
            end
            if (mac_load) begin
                ld_q.push_back({mac_a, mac_b});
                ld_cyc.push_back(cyc);
                last_ld = cyc;
            end
            if (vec_done) begin
                dn_q.push_back({vec_len, len_ovf});
                chk("done_latency", cyc, last_ld + LAT + 1);
                chk("sclr_per_vector", pend, 1);
                pend = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_logs();
        ld_q.delete();
        dn_q.delete();
        ld_cyc.delete();
        sc_cyc.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_ctrl"}, {mac_sclr, mac_load, vec_done, len_ovf, busy}, 0);
        chk({tag, "_mac_ab"}, {mac_a, mac_b}, 0);
        chk({tag, "_vec_len"}, vec_len, 0);
    endtask

    task automatic push_elem(input logic [3:0] a, input logic [3:0] b, input logic last);
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_last = last;
        while (!acc && n < 200) begin
            @(negedge sys_clock);
            acc = in_ready;
            @(posedge sys_clock);
            #1;
            n++;
        end
        if (!acc) chk("push_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int w;
        w = 0;
        while (dn_q.size() < n && w < 600) begin
            @(posedge sys_clock);
            w++;
        end
        chk("done_count", dn_q.size(), n);
        repeat (3) @(posedge sys_clock);
        #1;
    endtask

    // (1,1,last) then six pairs held valid; the long DRAIN fills the FIFO.
    task automatic run_fill(input logic final_last);
        int idx;
        in_valid = 1'b1;
        in_a = 4'd1;
        in_b = 4'd1;
        in_last = 1'b1;
        @(negedge sys_clock);
        chk("fill_first_ready", in_ready, 1);
        @(posedge sys_clock);
        #1;
        idx = 0;
        for (int k = 1; k <= 13; k++) begin
            in_valid = idx < 6;
            in_a = 4'(10 + idx);
            in_b = 4'(idx + 1);
            in_last = final_last && idx == 5;
            @(negedge sys_clock);
            chk("fill_ready", in_ready, (k >= 5 && k <= 11) ? 0 : 1);
            if (in_ready && in_valid) idx++;
            @(posedge sys_clock);
            #1;
        end
        in_valid = 1'b0;
        chk("fill_accepted", idx, 6);
    endtask

    initial begin
        int j;
        int t0;
        tbl[0] = '{4'd1, 4'd2, 1'b0, 4'd0, 1'b0};
        tbl[1] = '{4'd3, 4'd4, 1'b0, 4'd0, 1'b0};
        tbl[2] = '{4'd5, 4'd6, 1'b1, 4'd3, 1'b0};
        tbl[3] = '{4'd9, 4'd9, 1'b1, 4'd1, 1'b0};
        tbl[4] = '{4'd1, 4'd1, 1'b1, 4'd1, 1'b0};
        for (int i = 0; i < 16; i++) tbl[5 + i] = '{4'(i), 4'(15 - i), i == 15, 4'd15, 1'b1};
        tbl[21] = '{4'd8, 4'd3, 1'b0, 4'd0, 1'b0};
        tbl[22] = '{4'd4, 4'd7, 1'b1, 4'd2, 1'b0};

        repeat (2) @(posedge sys_clock);
        #1;
        chk_reset_outputs("reset");
        @(negedge sys_clock);
        sys_rst_n = 1'b1;
        repeat (2) @(posedge sys_clock);
        #1;

        clear_logs();
        for (int i = 0; i < 23; i++) push_elem(tbl[i].a, tbl[i].b, tbl[i].last);
        wait_done(5);
        chk("tbl_load_count", ld_q.size(), 23);
        for (int i = 0; i < 23; i++) chk("tbl_load", ld_q[i], {tbl[i].a, tbl[i].b});
        j = 0;
        for (int i = 0; i < 23; i++) begin
            if (tbl[i].last) begin
                chk("tbl_done", dn_q[j], {tbl[i].len, tbl[i].ovf});
                j++;
            end
        end
        chk("tbl_sclr_count", sc_cyc.size(), 5);
        chk("v1_sclr_to_load", ld_cyc[0] - sc_cyc[0], 1);
        chk("v1_consecutive", ld_cyc[2] - ld_cyc[0], 2);
        chk("tbl_idle", busy, 0);

        clear_logs();
        t0 = cyc;
        in_valid = 1'b1;
        in_a = 4'd7;
        in_b = 4'd1;
        in_last = 1'b0;
        @(negedge sys_clock);
        chk("gap_first_ready", in_ready, 1);
        @(posedge sys_clock);
        #1;
        for (int k = 1; k <= 7; k++) begin
            in_valid = k == 5;
            in_a = 4'd2;
            in_b = 4'd2;
            in_last = 1'b1;
            @(negedge sys_clock);
            if (k >= 4 && k <= 6) begin
                chk("gap_bubble_load", mac_load, 0);
                chk("gap_bubble_hold", {mac_a, mac_b}, 8'h71);
            end
            if (k == 5) chk("gap_second_ready", in_ready, 1);
            @(posedge sys_clock);
            #1;
        end
        in_valid = 1'b0;
        wait_done(1);
        chk("gap_sclr_latency", sc_cyc[0] - t0, 2);
        chk("gap_load_latency", ld_cyc[0] - t0, 3);
        chk("gap_second_load", ld_cyc[1] - t0, 7);
        chk("gap_load0", ld_q[0], 8'h71);
        chk("gap_load1", ld_q[1], 8'h22);
        chk("gap_done", dn_q[0], {4'd2, 1'b0});

        clear_logs();
        run_fill(1'b1);
        wait_done(2);
        chk("fill_load_count", ld_q.size(), 7);
        chk("fill_load0", ld_q[0], 8'h11);
        for (int i = 0; i < 6; i++) chk("fill_load", ld_q[1 + i], {4'(10 + i), 4'(i + 1)});
        chk("fill_done0", dn_q[0], {4'd1, 1'b0});
        chk("fill_done1", dn_q[1], {4'd6, 1'b0});

        clear_logs();
        run_fill(1'b0);
        chk("rst_pre_busy", busy, 1);
        chk("rst_pre_load", {mac_load, mac_a}, {1'b1, 4'd12});
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        repeat (3) @(posedge sys_clock);
        @(negedge sys_clock);
        #1;
        sys_rst_n = 1'b1;
        clear_logs();
        repeat (20) @(posedge sys_clock);
        #1;
        chk("post_rst_loads", ld_q.size(), 0);
        chk("post_rst_sclr", sc_cyc.size(), 0);
        chk("post_rst_done", dn_q.size(), 0);
        chk("post_rst_state", {busy, in_ready}, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
